// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - pipeline stall/flush arbitration for memory, muldiv, branch and load-use events
module pipeline_stall_controller #(
    parameter int MULDIV_MAX_CYCLES = 40,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 LU_HAZARD,
    input  logic                 BRANCH_TAKEN_EX,
    input  logic                 MULDIV_START_EX,
    input  logic                 MULDIV_DONE,
    input  logic                 DMEM_BUSY,
    output logic                 PC_STALL,
    output logic                 IF_ID_STALL,
    output logic                 ID_EX_STALL,
    output logic                 EX_MEM_STALL,
    output logic                 IF_ID_FLUSH,
    output logic                 ID_EX_FLUSH,
    output logic                 EX_MEM_FLUSH,
    output logic                 MEM_WB_FLUSH,
    output logic                 MULDIV_TIMEOUT,
    output logic [CNT_WIDTH-1:0] STALL_CYCLES
);

    localparam int MD_W = $clog2(MULDIV_MAX_CYCLES + 1);
    // Last MULDIV_WAIT counter value; one more undone cycle here means timeout.
    localparam logic [MD_W-1:0] MD_LAST = MD_W'(MULDIV_MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_MULDIV_WAIT = 2'd1,
        ST_MEM_WAIT    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 ret_muldiv_q, ret_muldiv_d;
    logic [MD_W-1:0]      md_cnt_q, md_cnt_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q;

    logic pc_stall_c, if_id_stall_c, id_ex_stall_c, ex_mem_stall_c;
    logic if_id_flush_c, id_ex_flush_c, ex_mem_flush_c, mem_wb_flush_c;
    logic release_c;

    // Next state and stall/flush decode; priority is DMEM_BUSY, then muldiv, then branch, then load-use.
    always_comb begin
        state_d        = state_q;
        ret_muldiv_d   = ret_muldiv_q;
        md_cnt_d       = md_cnt_q;
        timeout_d      = timeout_q;
        pc_stall_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        id_ex_stall_c  = 1'b0;
        ex_mem_stall_c = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_flush_c = 1'b0;
        mem_wb_flush_c = 1'b0;
        release_c      = 1'b0;

        if (DMEM_BUSY) begin
            // Whole front of the pipe holds; the MEM result is replaced by a bubble.
            pc_stall_c     = 1'b1;
            if_id_stall_c  = 1'b1;
            id_ex_stall_c  = 1'b1;
            ex_mem_stall_c = 1'b1;
            mem_wb_flush_c = 1'b1;
            state_d        = ST_MEM_WAIT;
            if (state_q != ST_MEM_WAIT) begin
                ret_muldiv_d = (state_q == ST_MULDIV_WAIT);
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (MULDIV_START_EX && !MULDIV_DONE) begin
                        pc_stall_c     = 1'b1;
                        if_id_stall_c  = 1'b1;
                        id_ex_stall_c  = 1'b1;
                        ex_mem_flush_c = 1'b1;
                        md_cnt_d       = '0;
                        state_d        = ST_MULDIV_WAIT;
                    end else if (BRANCH_TAKEN_EX) begin
                        // A taken branch squashes a load-use stall: the dependent op is flushed anyway.
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end else if (LU_HAZARD) begin
                        pc_stall_c    = 1'b1;
                        if_id_stall_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end
                end
                ST_MULDIV_WAIT: begin
                    if (MULDIV_DONE) begin
                        release_c = 1'b1;
                        state_d   = ST_RUN;
                    end else if (md_cnt_q == MD_LAST) begin
                        release_c = 1'b1;
                        timeout_d = 1'b1;
                        state_d   = ST_RUN;
                    end else begin
                        pc_stall_c     = 1'b1;
                        if_id_stall_c  = 1'b1;
                        id_ex_stall_c  = 1'b1;
                        ex_mem_flush_c = 1'b1;
                        md_cnt_d       = md_cnt_q + MD_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    // Muldiv counter intentionally untouched so a resumed wait keeps its budget.
                    release_c = 1'b1;
                    state_d   = ret_muldiv_q ? ST_MULDIV_WAIT : ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase

            // A branch held in EX during a stall gets its flush when the stall lets go.
            if (release_c && BRANCH_TAKEN_EX) begin
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
            end
        end
    end

    // State, muldiv budget, sticky timeout and saturating stall-cycle counter.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= ST_RUN;
            ret_muldiv_q <= 1'b0;
            md_cnt_q     <= '0;
            timeout_q    <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            ret_muldiv_q <= ret_muldiv_d;
            md_cnt_q     <= md_cnt_d;
            timeout_q    <= timeout_d;
            if (pc_stall_c && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Outputs are combinational, so reset must mask them directly to take effect without a clock.
    assign PC_STALL       = RESET & pc_stall_c;
    assign IF_ID_STALL    = RESET & if_id_stall_c;
    assign ID_EX_STALL    = RESET & id_ex_stall_c;
    assign EX_MEM_STALL   = RESET & ex_mem_stall_c;
    assign IF_ID_FLUSH    = RESET & if_id_flush_c;
    assign ID_EX_FLUSH    = RESET & id_ex_flush_c;
    assign EX_MEM_FLUSH   = RESET & ex_mem_flush_c;
    assign MEM_WB_FLUSH   = RESET & mem_wb_flush_c;
    assign MULDIV_TIMEOUT = timeout_q;
    assign STALL_CYCLES   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed vector bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

    logic        CLK;
    logic        RESET;
    logic        LU_HAZARD, BRANCH_TAKEN_EX, MULDIV_START_EX, MULDIV_DONE, DMEM_BUSY;
    logic        PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL;
    logic        IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH;
    logic        MULDIV_TIMEOUT;
    logic [15:0] STALL_CYCLES;
    logic [7:0]  outs;

    int errors = 0;
    int checks = 0;

    // {pc_s, ifid_s, idex_s, exmem_s, ifid_f, idex_f, exmem_f, memwb_f}
    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_LU   = 8'b1100_0100;
    localparam logic [7:0] O_MD   = 8'b1110_0010;
    localparam logic [7:0] O_MEM  = 8'b1111_0001;
    localparam logic [7:0] O_BR   = 8'b0000_1100;

    typedef struct {
        logic        rst, lu, br, ms, md, bz;
        logic [7:0]  outs;
        logic        to;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    pipeline_stall_controller #(
        .MULDIV_MAX_CYCLES(40),
        .CNT_WIDTH(16)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .LU_HAZARD(LU_HAZARD),
        .BRANCH_TAKEN_EX(BRANCH_TAKEN_EX),
        .MULDIV_START_EX(MULDIV_START_EX),
        .MULDIV_DONE(MULDIV_DONE),
        .DMEM_BUSY(DMEM_BUSY),
        .PC_STALL(PC_STALL),
        .IF_ID_STALL(IF_ID_STALL),
        .ID_EX_STALL(ID_EX_STALL),
        .EX_MEM_STALL(EX_MEM_STALL),
        .IF_ID_FLUSH(IF_ID_FLUSH),
        .ID_EX_FLUSH(ID_EX_FLUSH),
        .EX_MEM_FLUSH(EX_MEM_FLUSH),
        .MEM_WB_FLUSH(MEM_WB_FLUSH),
        .MULDIV_TIMEOUT(MULDIV_TIMEOUT),
        .STALL_CYCLES(STALL_CYCLES)
    );

    assign outs = {PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL,
                   IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic void add(input logic rst, lu, br, ms, md, bz,
                                input logic [7:0] o, input logic to, input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.lu = lu; v.br = br; v.ms = ms; v.md = md; v.bz = bz;
        v.outs = o; v.to = to; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic rst, lu, br, ms, md, bz);
        RESET = rst; LU_HAZARD = lu; BRANCH_TAKEN_EX = br;
        MULDIV_START_EX = ms; MULDIV_DONE = md; DMEM_BUSY = bz;
    endtask

    task automatic check(input string name, input logic [7:0] eo, input logic eto, input logic [15:0] ecnt);
        checks++;
        if (outs !== eo) begin
            errors++;
            $display("FAIL %s outs got=%b want=%b", name, outs, eo);
        end
        checks++;
        if (MULDIV_TIMEOUT !== eto) begin
            errors++;
            $display("FAIL %s timeout got=%b want=%b", name, MULDIV_TIMEOUT, eto);
        end
        checks++;
        if (STALL_CYCLES !== ecnt) begin
            errors++;
            $display("FAIL %s stall_cycles got=%0d want=%0d", name, STALL_CYCLES, ecnt);
        end
    endtask

    // One clocked step: inputs driven 1 after the edge, outputs checked 4 after the edge.
    task automatic step(input string name, input logic lu, br, ms, md, bz,
                        input logic [7:0] eo, input logic eto, input logic [15:0] ecnt);
        drive(1'b1, lu, br, ms, md, bz);
        #3;
        check(name, eo, eto, ecnt);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        //   rst lu br ms md bz  outs    to cnt
        add(0, 0, 0, 0, 0, 1, O_NONE, 0, 0);   // reset masks DMEM_BUSY
        add(0, 0, 0, 0, 0, 0, O_NONE, 0, 0);
        add(1, 0, 0, 0, 0, 0, O_NONE, 0, 0);
        add(1, 1, 0, 0, 0, 0, O_LU,   0, 0);   // load-use, one cycle
        add(1, 0, 0, 0, 0, 0, O_NONE, 0, 1);
        add(1, 0, 0, 1, 0, 0, O_MD,   0, 1);   // muldiv start
        add(1, 0, 0, 0, 0, 0, O_MD,   0, 2);
        add(1, 0, 0, 0, 0, 0, O_MD,   0, 3);
        add(1, 0, 0, 0, 0, 0, O_MD,   0, 4);
        add(1, 0, 0, 0, 0, 0, O_MD,   0, 5);
        add(1, 0, 0, 0, 0, 0, O_MD,   0, 6);
        add(1, 0, 0, 0, 1, 0, O_NONE, 0, 7);   // done: released, 6 stall cycles
        add(1, 0, 0, 0, 0, 0, O_NONE, 0, 7);
        add(1, 1, 1, 0, 0, 0, O_BR,   0, 7);   // branch beats load-use
        add(1, 0, 1, 0, 0, 0, O_BR,   0, 7);
        add(1, 0, 1, 0, 0, 1, O_MEM,  0, 7);   // branch suppressed under mem stall
        add(1, 0, 1, 0, 0, 1, O_MEM,  0, 8);
        add(1, 0, 1, 0, 0, 0, O_BR,   0, 9);   // flush on release
        add(1, 0, 0, 0, 0, 0, O_NONE, 0, 9);
        add(1, 0, 0, 1, 1, 0, O_NONE, 0, 9);   // single-cycle muldiv
        add(1, 0, 0, 1, 0, 0, O_MD,   0, 9);   // muldiv interrupted by memory
        add(1, 0, 0, 0, 0, 0, O_MD,   0, 10);
        add(1, 0, 0, 0, 0, 1, O_MEM,  0, 11);
        add(1, 0, 0, 0, 0, 1, O_MEM,  0, 12);
        add(1, 0, 0, 0, 0, 1, O_MEM,  0, 13);
        add(1, 0, 0, 0, 0, 0, O_NONE, 0, 14);  // release, back to MULDIV_WAIT
        add(1, 0, 0, 0, 0, 0, O_MD,   0, 14);
        add(1, 0, 0, 0, 1, 0, O_NONE, 0, 15);
        add(1, 0, 0, 0, 0, 0, O_NONE, 0, 15);
        add(1, 0, 0, 1, 0, 1, O_MEM,  0, 15);  // memory beats muldiv start
        add(1, 0, 0, 0, 0, 0, O_NONE, 0, 16);

        @(posedge CLK);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].lu, vecs[i].br, vecs[i].ms, vecs[i].md, vecs[i].bz);
            #3;
            check($sformatf("vec%0d", i), vecs[i].outs, vecs[i].to, vecs[i].cnt);
            @(posedge CLK);
            #1;
        end

        // Timeout with a memory hold in the middle: the muldiv budget must not advance while held.
        step("to_start", 0, 0, 1, 0, 0, O_MD, 0, 16);
        for (int i = 0; i < 10; i++) step($sformatf("to_wait_a%0d", i), 0, 0, 0, 0, 0, O_MD, 0, 16'(17 + i));
        for (int i = 0; i < 3; i++) step($sformatf("to_mem%0d", i), 0, 0, 0, 0, 1, O_MEM, 0, 16'(27 + i));
        step("to_mem_release", 0, 0, 0, 0, 0, O_NONE, 0, 30);
        for (int i = 0; i < 29; i++) step($sformatf("to_wait_b%0d", i), 0, 0, 0, 0, 0, O_MD, 0, 16'(30 + i));
        step("to_fire", 0, 0, 0, 0, 0, O_NONE, 0, 59);
        step("to_sticky", 0, 0, 0, 0, 0, O_NONE, 1, 59);
        step("to_sticky_op", 0, 0, 1, 1, 0, O_NONE, 1, 59);

        // Asynchronous reset in the middle of a muldiv wait.
        step("rst_md_start", 0, 0, 1, 0, 0, O_MD, 1, 59);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        check("rst_md_wait", O_MD, 1, 60);
        RESET = 1'b0;
        #1;
        check("rst_async", O_NONE, 0, 0);
        @(posedge CLK);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #3;
        check("rst_hold", O_NONE, 0, 0);
        @(posedge CLK);
        #1;
        step("rst_resume_idle", 0, 0, 0, 0, 0, O_NONE, 0, 0);
        step("rst_resume_lu", 1, 0, 0, 0, 0, O_LU, 0, 0);
        step("rst_resume_cnt", 0, 0, 0, 0, 0, O_NONE, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter MULDIV_MAX_CYCLES, default 40, maximum EX-stage cycles a multiply/divide may occupy before timeout.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the stall-cycle performance counter.
REQ-003 SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port LU_HAZARD  input  1  load-use hazard flag from the hazard detection unit.
REQ-006 SHALL have port BRANCH_TAKEN_EX  input  1  taken branch/jump resolved in EX.
REQ-007 SHALL have port MULDIV_START_EX  input  1  M-extension instruction entering EX this cycle.
REQ-008 SHALL have port MULDIV_DONE  input  1  multiply/divide result valid this cycle.
REQ-009 SHALL have port DMEM_BUSY  input  1  data memory not ready, MEM stage must hold.
REQ-010 SHALL have ports PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL  output  1 each  hold the named register.
REQ-011 SHALL have ports IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH  output  1 each  load a bubble (NOP) into the named register.
REQ-012 SHALL have port MULDIV_TIMEOUT  output  1  sticky error flag.
REQ-013 SHALL have port STALL_CYCLES  output  CNT_WIDTH  saturating count of cycles with PC_STALL=1.

Function
REQ-014 SHALL implement states RUN, MULDIV_WAIT, MEM_WAIT; outputs combinational from state plus current inputs.
REQ-015 SHALL, in any state, when DMEM_BUSY=1: assert PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_FLUSH; all other flushes 0; next state MEM_WAIT (from RUN or MULDIV_WAIT, remembering return target).
REQ-016 SHALL, in MEM_WAIT with DMEM_BUSY=0, release all stalls that cycle and return to the remembered state (RUN or MULDIV_WAIT); the muldiv cycle counter is frozen while in MEM_WAIT.
REQ-017 SHALL, in RUN with MULDIV_START_EX=1 and DMEM_BUSY=0, assert PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_FLUSH and go to MULDIV_WAIT, clearing the muldiv cycle counter.
REQ-018 SHALL, in MULDIV_WAIT with MULDIV_DONE=0, assert the same signals as REQ-017 and increment the counter.
REQ-019 SHALL, in MULDIV_WAIT with MULDIV_DONE=1, deassert all stalls/flushes that cycle and return to RUN; MULDIV_DONE=1 coincident with MULDIV_START_EX in RUN SHALL produce no stall (single-cycle op).
REQ-020 SHALL, when the counter reaches MULDIV_MAX_CYCLES without MULDIV_DONE, set MULDIV_TIMEOUT=1, deassert stalls that cycle, return to RUN.
REQ-021 SHALL, in RUN with BRANCH_TAKEN_EX=1 and no stall condition, assert IF_ID_FLUSH and ID_EX_FLUSH only; PC not stalled.
REQ-022 SHALL suppress branch flushes while any stall is active; the branch remains in EX and its flush SHALL occur in the release cycle.
REQ-023 SHALL, in RUN with LU_HAZARD=1 and BRANCH_TAKEN_EX=0, assert PC_STALL, IF_ID_STALL, ID_EX_FLUSH for that cycle only.
REQ-024 SHALL give priority DMEM_BUSY > muldiv > BRANCH_TAKEN_EX > LU_HAZARD; LU_HAZARD with BRANCH_TAKEN_EX produces flush only (no stall).
REQ-025 SHALL never assert a stall and a flush on the same pipeline register in one cycle.
REQ-026 SHALL increment STALL_CYCLES on every edge where PC_STALL=1, saturating at 2^CNT_WIDTH-1.

Reset
REQ-027 SHALL, while RESET=0, force state RUN, counters 0, MULDIV_TIMEOUT=0, STALL_CYCLES=0, all stall/flush outputs 0, asynchronously, including mid-MULDIV_WAIT or mid-MEM_WAIT.
REQ-028 SHALL resume normal operation on the first rising CLK after RESET returns to 1.

Verification
REQ-029 LU_HAZARD=1 one cycle in RUN -> PC_STALL=IF_ID_STALL=ID_EX_FLUSH=1 that cycle, 0 next; STALL_CYCLES=1.
REQ-030 MULDIV_START_EX=1, MULDIV_DONE after 5 more cycles -> stalls high 6 cycles total, released on DONE cycle, STALL_CYCLES=6.
REQ-031 DMEM_BUSY=1 for 3 cycles during MULDIV_WAIT (DONE low) -> MEM_WB_FLUSH=1 those 3 cycles, then returns to MULDIV_WAIT with counter unchanged.
REQ-032 BRANCH_TAKEN_EX=1 with LU_HAZARD=1 -> IF_ID_FLUSH=ID_EX_FLUSH=1, PC_STALL=0; same with DMEM_BUSY=1 -> no flush until DMEM_BUSY falls.
REQ-033 MULDIV_START_EX then no DONE for 40 cycles -> MULDIV_TIMEOUT=1 sticky, state RUN, stalls released.
REQ-034 RESET=0 asserted mid-MULDIV_WAIT -> all outputs 0 immediately without CLK edge; STALL_CYCLES=0.
